interp_request_sequencer: RTL and testbench

Upstream driver for the interpolation module. It walks a run of output time points, where tk = t_start + i*t_step. For each point it presents tk and the destination u-vector base address, pulses the interpolator's start, and waits for its done. It issues a one-time init pulse at the start of each run and reports run completion, progress and errors to the top-level controller.

---
 rtl/interp_request_sequencer_if.sv | 32 +++
 rtl/interp_request_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_interp_request_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/interp_request_sequencer_if.sv
// Handshake bundle between the request sequencer and the interpolation module.
// The sequencer drives tk/uk and the init/start pulses; the interpolator
// answers with done and its overflow flag.
interface interp_request_sequencer_if #(
    parameter int WORD_SIZE     = 16,
    parameter int ADDRESS_WIDTH = 16
);
    logic                     interp_init;
    logic                     interp_start;
    logic [WORD_SIZE-1:0]     tk_out;
    logic [ADDRESS_WIDTH-1:0] uk_out;
    logic                     interp_done;
    logic                     interp_overflow;

    modport master (
        output interp_init,
        output interp_start,
        output tk_out,
        output uk_out,
        input  interp_done,
        input  interp_overflow
    );

    modport slave (
        input  interp_init,
        input  interp_start,
        input  tk_out,
        input  uk_out,
        output interp_done,
        output interp_overflow
    );
endinterface

// File: rtl/interp_request_sequencer.sv
// Upstream driver for the interpolator: walks tk = t_start + i*t_step over a
// run of n_points, issuing one start per point and waiting for done, with a
// single init pulse per run. Reports completion, progress and sticky errors.
module interp_request_sequencer #(
    parameter int                       WORD_SIZE     = 16,
    parameter int                       ADDRESS_WIDTH = 16,
    parameter int                       FRAC_BITS     = 7,
    parameter logic [ADDRESS_WIDTH-1:0] U_STRIDE      = 16'h0200,
    parameter int                       TIMEOUT       = 1023,
    parameter int                       CNT_WIDTH     = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         go,
    input  logic [WORD_SIZE-1:0]         t_start,
    input  logic [WORD_SIZE-1:0]         t_step,
    input  logic [CNT_WIDTH-1:0]         n_points,
    input  logic [ADDRESS_WIDTH-1:0]     uk_base,
    interp_request_sequencer_if.master   interp,
    output logic [CNT_WIDTH-1:0]         point_idx,
    output logic                         busy,
    output logic                         seq_done,
    output logic                         error,
    output logic [1:0]                   err_code
);

    // The fixed-point split only matters to the interpolator, but it must leave
    // at least one integer bit in the word.
    if (FRAC_BITS >= WORD_SIZE) begin : g_bad_frac
        $error("FRAC_BITS must be smaller than WORD_SIZE");
    end

    localparam int                   TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]     TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam int                   MSB      = WORD_SIZE - 1;

    localparam logic [1:0] ERR_TK_OVF  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_INTERP  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ISSUE,
        WAIT,
        ADVANCE,
        DONE,
        ERR
    } state_t;

    state_t                   state_q, next_state;
    logic [WORD_SIZE-1:0]     t_step_q, t_step_d;
    logic [CNT_WIDTH-1:0]     n_points_q, n_points_d;
    logic [WORD_SIZE-1:0]     tk_q, tk_d, tk_sum;
    logic [ADDRESS_WIDTH-1:0] uk_q, uk_d;
    logic [CNT_WIDTH-1:0]     idx_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic                     init_q, init_d;
    logic                     start_q, start_d;
    logic                     busy_d, seq_done_d, error_d;
    logic [1:0]               err_code_d;
    logic                     tk_ovf;

    assign interp.interp_init  = init_q;
    assign interp.interp_start = start_q;
    assign interp.tk_out       = tk_q;
    assign interp.uk_out       = uk_q;

    // Next-state and next-register values; every output is registered from these.
    always_comb begin
        next_state = state_q;
        t_step_d   = t_step_q;
        n_points_d = n_points_q;
        tk_d       = tk_q;
        uk_d       = uk_q;
        idx_d      = point_idx;
        timer_d    = timer_q;
        init_d     = 1'b0;
        start_d    = 1'b0;
        seq_done_d = 1'b0;
        error_d    = error;
        err_code_d = err_code;
        tk_sum     = tk_q + t_step_q;
        tk_ovf     = (tk_q[MSB] == t_step_q[MSB]) && (tk_sum[MSB] != tk_q[MSB]);

        case (state_q)
            IDLE, DONE, ERR: begin
                if (go) begin
                    error_d    = 1'b0;
                    err_code_d = 2'b00;
                    if (n_points == '0) begin
                        next_state = DONE;
                        seq_done_d = 1'b1;
                    end else begin
                        t_step_d   = t_step;
                        n_points_d = n_points;
                        tk_d       = t_start;
                        uk_d       = uk_base;
                        idx_d      = '0;
                        next_state = INIT;
                        init_d     = 1'b1;
                    end
                end
            end
            INIT: begin
                next_state = ISSUE;
                start_d    = 1'b1;
            end
            ISSUE: begin
                timer_d    = '0;
                next_state = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + TMR_ONE;
                if (interp.interp_overflow) begin
                    next_state = ERR;
                    error_d    = 1'b1;
                    err_code_d = ERR_INTERP;
                end else if (interp.interp_done) begin
                    next_state = ADVANCE;
                end else if (timer_q == TMR_LAST) begin
                    next_state = ERR;
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            ADVANCE: begin
                if ((point_idx + CNT_ONE) == n_points_q) begin
                    next_state = DONE;
                    seq_done_d = 1'b1;
                end else if (tk_ovf) begin
                    next_state = ERR;
                    error_d    = 1'b1;
                    err_code_d = ERR_TK_OVF;
                end else begin
                    tk_d       = tk_sum;
                    uk_d       = uk_q + U_STRIDE;
                    idx_d      = point_idx + CNT_ONE;
                    next_state = ISSUE;
                    start_d    = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase

        busy_d = (next_state == INIT) || (next_state == ISSUE) ||
                 (next_state == WAIT) || (next_state == ADVANCE);
    end

    // State and registered outputs; reset clears everything and aborts any run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            t_step_q   <= '0;
            n_points_q <= '0;
            tk_q       <= '0;
            uk_q       <= '0;
            point_idx  <= '0;
            timer_q    <= '0;
            init_q     <= 1'b0;
            start_q    <= 1'b0;
            busy       <= 1'b0;
            seq_done   <= 1'b0;
            error      <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            state_q    <= next_state;
            t_step_q   <= t_step_d;
            n_points_q <= n_points_d;
            tk_q       <= tk_d;
            uk_q       <= uk_d;
            point_idx  <= idx_d;
            timer_q    <= timer_d;
            init_q     <= init_d;
            start_q    <= start_d;
            busy       <= busy_d;
            seq_done   <= seq_done_d;
            error      <= error_d;
            err_code   <= err_code_d;
        end
    end

endmodule

// File: tb/tb_interp_request_sequencer.sv
// Self-checking bench for interp_request_sequencer: directed scenarios plus
// randomized runs compared against a simple arithmetic model of the run.
module tb_interp_request_sequencer;
    localparam int WS  = 16;
    localparam int AW  = 16;
    localparam int CW  = 10;
    localparam int TMO = 8;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          go       = 1'b0;
    logic [WS-1:0] t_start  = '0;
    logic [WS-1:0] t_step   = '0;
    logic [CW-1:0] n_points = '0;
    logic [AW-1:0] uk_base  = '0;
    logic [CW-1:0] point_idx;
    logic          busy;
    logic          seq_done;
    logic          error;
    logic [1:0]    err_code;

    int checks    = 0;
    int errors    = 0;
    int init_cnt  = 0;
    int start_cnt = 0;
    int done_cnt  = 0;

    interp_request_sequencer_if #(.WORD_SIZE(WS), .ADDRESS_WIDTH(AW)) ifc ();

    interp_request_sequencer #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .t_start   (t_start),
        .t_step    (t_step),
        .n_points  (n_points),
        .uk_base   (uk_base),
        .interp    (ifc.master),
        .point_idx (point_idx),
        .busy      (busy),
        .seq_done  (seq_done),
        .error     (error),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    // Tally pulses as seen by the rising edge so pulse counts can be checked per run
    always @(posedge clk) begin
        if (ifc.interp_init)  init_cnt++;
        if (ifc.interp_start) start_cnt++;
        if (seq_done)         done_cnt++;
    end

    // Hard stop in case anything wedges
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present run parameters with a one-cycle go; returns in cycle 1 of the run
    task automatic applyStimulus(input logic [15:0] ts, input logic [15:0] st,
                                 input logic [9:0] n, input logic [15:0] ub);
        t_start  = ts;
        t_step   = st;
        n_points = n;
        uk_base  = ub;
        go       = 1'b1;
        @(negedge clk);
        go       = 1'b0;
    endtask

    // Drive a whole run and compare against tk_i = ts + i*st, uk_i = ub + i*0x200
    task automatic runRun(input logic [15:0] ts, input logic [15:0] st, input int n,
                          input logic [15:0] ub, input int dly, input string tag);
        int          tk_i;
        int          uk_i;
        int          base_init;
        int          base_start;
        int          base_done;
        int          issued;
        logic [15:0] exp_tk;
        logic [15:0] exp_uk;
        base_init  = init_cnt;
        base_start = start_cnt;
        base_done  = done_cnt;
        applyStimulus(ts, st, 10'(n), ub);
        if (n == 0) begin
            checkOutput({tag, "/zero_seq_done"}, 32'(seq_done), 1);
            checkOutput({tag, "/zero_busy"}, 32'(busy), 0);
            checkOutput({tag, "/zero_init"}, 32'(ifc.interp_init), 0);
            @(negedge clk);
            checkOutput({tag, "/zero_seq_done_low"}, 32'(seq_done), 0);
            checkOutput({tag, "/zero_busy_low"}, 32'(busy), 0);
            checkOutput({tag, "/zero_pulses"}, 32'((init_cnt - base_init) + (start_cnt - base_start)), 0);
            return;
        end
        checkOutput({tag, "/init"}, 32'(ifc.interp_init), 1);
        checkOutput({tag, "/busy"}, 32'(busy), 1);
        checkOutput({tag, "/err_cleared"}, {29'd0, error, err_code}, 0);
        @(negedge clk);
        tk_i   = int'($signed(ts));
        issued = 0;
        for (int i = 0; i < n; i++) begin
            uk_i   = int'(ub) + i * 512;
            exp_tk = tk_i[15:0];
            exp_uk = uk_i[15:0];
            checkOutput({tag, "/start"}, 32'(ifc.interp_start), 1);
            checkOutput({tag, "/tk"}, 32'(ifc.tk_out), 32'(exp_tk));
            checkOutput({tag, "/uk"}, 32'(ifc.uk_out), 32'(exp_uk));
            checkOutput({tag, "/idx"}, 32'(point_idx), i);
            issued++;
            repeat (dly) @(negedge clk);
            checkOutput({tag, "/wait_tk_stable"}, 32'(ifc.tk_out), 32'(exp_tk));
            ifc.interp_done = 1'b1;
            @(negedge clk);
            ifc.interp_done = 1'b0;
            @(negedge clk);
            if (i == n - 1) begin
                checkOutput({tag, "/seq_done"}, 32'(seq_done), 1);
                checkOutput({tag, "/done_busy"}, 32'(busy), 0);
                checkOutput({tag, "/last_tk"}, 32'(ifc.tk_out), 32'(exp_tk));
                checkOutput({tag, "/last_uk"}, 32'(ifc.uk_out), 32'(exp_uk));
                checkOutput({tag, "/last_idx"}, 32'(point_idx), i);
                @(negedge clk);
                checkOutput({tag, "/seq_done_low"}, 32'(seq_done), 0);
                checkOutput({tag, "/n_init"}, 32'(init_cnt - base_init), 1);
                checkOutput({tag, "/n_start"}, 32'(start_cnt - base_start), 32'(issued));
                checkOutput({tag, "/n_done"}, 32'(done_cnt - base_done), 1);
            end else if ((tk_i + int'($signed(st)) > 32767) || (tk_i + int'($signed(st)) < -32768)) begin
                checkOutput({tag, "/ovf_error"}, 32'(error), 1);
                checkOutput({tag, "/ovf_code"}, 32'(err_code), 1);
                checkOutput({tag, "/ovf_tk"}, 32'(ifc.tk_out), 32'(exp_tk));
                checkOutput({tag, "/ovf_busy"}, 32'(busy), 0);
                checkOutput({tag, "/ovf_n_start"}, 32'(start_cnt - base_start), 32'(issued));
                return;
            end else begin
                tk_i = tk_i + int'($signed(st));
            end
        end
    endtask

    initial begin
        int          base_start;
        int          base_init;
        int          base_done;
        int          sv;
        logic [15:0] rts;
        logic [15:0] rst_step;
        ifc.interp_done     = 1'b0;
        ifc.interp_overflow = 1'b0;

        // Reset held for two cycles with go asserted
        rst = 1'b0;
        go  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset/outs", {16'd0, 6'd0, point_idx}, 0);
        checkOutput("reset/tk_uk", {ifc.tk_out, ifc.uk_out}, 0);
        checkOutput("reset/flags", {26'd0, ifc.interp_init, ifc.interp_start, busy, seq_done, error, 1'b0} |
                                   {30'd0, err_code}, 0);
        checkOutput("reset/pulses", 32'(init_cnt + start_cnt + done_cnt), 0);
        rst = 1'b1;
        go  = 1'b0;
        @(negedge clk);

        // Normal run from the plan
        runRun(16'h0080, 16'h0040, 3, 16'h0400, 5, "normal");

        // done while not waiting is ignored
        base_start = start_cnt;
        base_done  = done_cnt;
        ifc.interp_done = 1'b1;
        @(negedge clk);
        ifc.interp_done = 1'b0;
        @(negedge clk);
        checkOutput("stray_done/busy", 32'(busy), 0);
        checkOutput("stray_done/pulses", 32'((start_cnt - base_start) + (done_cnt - base_done)), 0);

        // Zero-length run
        runRun(16'h1234, 16'h0010, 0, 16'h0000, 1, "zero");

        // tk overflow on the second point; error stays sticky
        runRun(16'h7F00, 16'h0200, 2, 16'h0000, 3, "tkovf");
        repeat (3) @(negedge clk);
        checkOutput("tkovf/sticky_error", 32'(error), 1);
        checkOutput("tkovf/sticky_code", 32'(err_code), 1);

        // Timeout: start in cycle s, ERR must appear in cycle s+9
        applyStimulus(16'h0100, 16'h0010, 10'd2, 16'h1000);
        checkOutput("tmo/err_cleared", 32'(error), 0);
        @(negedge clk);
        checkOutput("tmo/start", 32'(ifc.interp_start), 1);
        for (int j = 1; j <= TMO; j++) begin
            @(negedge clk);
            checkOutput("tmo/still_waiting", {30'd0, busy, error}, 32'h2);
        end
        @(negedge clk);
        checkOutput("tmo/error", 32'(error), 1);
        checkOutput("tmo/code", 32'(err_code), 2);
        checkOutput("tmo/busy", 32'(busy), 0);

        // Overflow beats done; go during WAIT is ignored
        base_init = init_cnt;
        applyStimulus(16'h0200, 16'h0080, 10'd3, 16'h2000);
        checkOutput("prio/err_cleared", 32'(error), 0);
        @(negedge clk);
        @(negedge clk);
        ifc.interp_done     = 1'b1;
        ifc.interp_overflow = 1'b1;
        go                  = 1'b1;
        t_start             = 16'h0F00;
        @(negedge clk);
        ifc.interp_done     = 1'b0;
        ifc.interp_overflow = 1'b0;
        go                  = 1'b0;
        checkOutput("prio/error", 32'(error), 1);
        checkOutput("prio/code", 32'(err_code), 3);
        checkOutput("prio/busy", 32'(busy), 0);
        @(negedge clk);
        checkOutput("prio/go_ignored", 32'(init_cnt - base_init), 1);
        checkOutput("prio/tk_kept", 32'(ifc.tk_out), 32'h0200);
        runRun(16'hFF80, 16'h0100, 2, 16'hFF00, 2, "restart");

        // Reset mid-run aborts with no completion pulse
        base_done = done_cnt;
        applyStimulus(16'h0300, 16'h0001, 10'd3, 16'h3000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checkOutput("midreset/state", {ifc.tk_out, ifc.uk_out} | {22'd0, point_idx}, 0);
        checkOutput("midreset/flags", {27'd0, busy, error, err_code, ifc.interp_start}, 0);
        ifc.interp_done = 1'b1;
        @(negedge clk);
        ifc.interp_done = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midreset/no_done", 32'(done_cnt - base_done), 0);
        checkOutput("midreset/idle", 32'(busy), 0);

        // Randomized runs against the arithmetic model
        for (int r = 0; r < 14; r++) begin
            rts = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rst_step = 16'($urandom);
            end else begin
                sv       = int'($urandom_range(0, 511)) - 256;
                rst_step = sv[15:0];
            end
            runRun(rts, rst_step, int'($urandom_range(0, 5)), 16'($urandom),
                   int'($urandom_range(1, TMO - 1)), "rand");
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
